mmio_timer_pwm: RTL and testbench
=================================

MMIO_TIMER_PWM -- requirements
Module: mmio_timer_pwm

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock in Hz; SHALL be an integer multiple of 1000000.
REQ-002 SHALL have parameter BASE_ADDR, default 32'hFFFFFF00, 256-byte-aligned base of the register window.
REQ-003 SHALL have parameter NUM_PWM, default 4, PWM channel count, legal range 1..16.
REQ-004 SHALL have parameter PWM_WIDTH, default 8, duty/counter width, legal range 4..16.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port funct3, input, 3, access size: [1] word, [0] halfword, else byte.
REQ-008 SHALL have port wren, input, 1, write strobe.
REQ-009 SHALL have port address, input, 32, byte address.
REQ-010 SHALL have port data_in, input, 32, write data, right-aligned.
REQ-011 SHALL have port data_out, output, 32, registered raw register word.
REQ-012 SHALL have port hit, output, 1, combinational: address[31:8] equals BASE_ADDR[31:8].
REQ-013 SHALL have port pwm_out, output, NUM_PWM, active-high PWM outputs.
REQ-014 SHALL have port irq, output, 1, level interrupt equal to TIMER_CTRL.pending.

Function
REQ-015 Word map (offset/4): 0 MICROS (R), 1 MILLIS (R), 2 TIMER_CMP (R/W), 3 TIMER_CTRL (R/W), 4..4+NUM_PWM-1 PWM_DUTY[n] (R/W, low PWM_WIDTH bits significant, upper bits read 0).
REQ-016 Reads SHALL have 1-cycle latency: data_out on edge k+1 reflects the register addressed at edge k; unmapped words in the window and non-hit addresses return 0.
REQ-017 Writes SHALL occur only when wren and hit; byte lanes: word = all 4; halfword = lanes {1,0} or {3,2} by address[1], taking data_in[15:0]; byte = lane address[1:0], taking data_in[7:0].
REQ-018 Writes to MICROS, MILLIS or unmapped words SHALL be ignored.
REQ-019 MICROS SHALL increment every CLK_FREQ/1000000 cycles; MILLIS every CLK_FREQ/1000 cycles; both wrap mod 2^32.
REQ-020 TIMER_CTRL bits: [0] enable, [1] auto_reload, [2] pending (write-1-to-clear), others read 0.
REQ-021 Internal 32-bit timer count SHALL increment on each microsecond tick while enable=1.
REQ-022 When enabled and count equals TIMER_CMP on a tick: pending<=1; auto_reload=1 -> count<=0, enable stays 1; auto_reload=0 -> enable<=0, count holds.
REQ-023 A write to TIMER_CMP, or a write setting enable from 0 to 1, SHALL reset count to 0.
REQ-024 A match and a W1C of pending in the same cycle: pending SHALL remain 1 (set wins).
REQ-025 TIMER_CMP=0 with enable=1 SHALL match on the first tick.
REQ-026 A shared PWM_WIDTH-bit counter SHALL free-run, wrapping 2^PWM_WIDTH-1 -> 0.
REQ-027 Each channel SHALL hold an active duty copied from PWM_DUTY[n] only when the counter wraps to 0 (glitch-free update).
REQ-028 pwm_out[n] SHALL be registered and equal (counter < active duty): duty 0 -> constant low; duty max -> low for 1 of 2^PWM_WIDTH cycles.

Reset
REQ-029 On reset asserted, all registers SHALL clear asynchronously: counters, MICROS, MILLIS, TIMER_CMP, TIMER_CTRL, timer count, duties, data_out, pwm_out, irq = 0.
REQ-030 Reset mid-operation SHALL abandon any pending write and restart prescalers from 0; first MICROS increment SHALL follow deassertion by CLK_FREQ/1000000 cycles.

Structure
REQ-031 Package mmio_pkg SHALL hold register word-offset constants, TIMER_CTRL bit indices and the funct3 size encodings.
REQ-032 Sub-module pwm_channel SHALL implement one channel (active-duty shadow + compare), instantiated NUM_PWM times by generate.

Verification (CLK_FREQ=12000000, defaults)
REQ-033 Release reset, read MICROS after 120 cycles -> 10 (±1); MILLIS after 12000 cycles -> 1.
REQ-034 Byte write 8'h80 to offset 0x11 (PWM_DUTY[0] lane 1), then word read offset 0x10 -> 32'h00000000 (upper bits masked); byte write 8'h80 to 0x10 -> pwm_out[0] high 128 of 256 cycles, change only at counter wrap.
REQ-035 TIMER_CMP=5, TIMER_CTRL=3 -> irq rises 6 ticks (72 cycles, ±12) later; W1C 32'h4 -> irq low; re-rises 6 ticks later.
REQ-036 TIMER_CMP=2, TIMER_CTRL=1 -> single irq, enable reads 0 afterwards, no further match.
REQ-037 W1C on pending in the match cycle -> irq stays 1.
REQ-038 Assert reset mid PWM period with duty 8'hFF -> pwm_out and irq 0 immediately, all reads 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared register map, TIMER_CTRL bit positions and access-size helpers
// for the MMIO timer/PWM block.
package mmio_pkg;

  localparam logic [5:0] W_MICROS = 6'd0;
  localparam logic [5:0] W_MILLIS = 6'd1;
  localparam logic [5:0] W_TCMP   = 6'd2;
  localparam logic [5:0] W_TCTRL  = 6'd3;
  localparam logic [5:0] W_PWM0   = 6'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_PEND = 2;

  localparam int F3_WORD_BIT = 1;
  localparam int F3_HALF_BIT = 0;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_lanes_t;

  function automatic size_e decode_size(input logic [2:0] funct3);
    if (funct3[F3_WORD_BIT]) return SZ_WORD;
    if (funct3[F3_HALF_BIT]) return SZ_HALF;
    return SZ_BYTE;
  endfunction

  // Right-aligned write data is replicated so every enabled lane sees its bytes.
  function automatic wr_lanes_t steer_write(input logic [2:0] funct3, input logic [1:0] alo,
                                            input logic [31:0] din);
    wr_lanes_t r;
    case (decode_size(funct3))
      SZ_WORD: begin r.mask = 4'hF; r.data = din; end
      SZ_HALF: begin r.mask = alo[1] ? 4'hC : 4'h3; r.data = {2{din[15:0]}}; end
      default: begin r.mask = 4'b0001 << alo; r.data = {4{din[7:0]}}; end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input wr_lanes_t w);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (w.mask[i]) r[i*8 +: 8] = w.data[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow reloaded only at counter wrap, registered compare.
module pwm_channel #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic                 wrap,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic                 pwm
);

  logic [PWM_WIDTH-1:0] active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wrap) active <= duty;
      pwm <= (cnt < active);
    end
  end

endmodule

// File: rtl/mmio_timer_pwm.sv
// MMIO timer/PWM peripheral: us/ms free-running counters, compare timer with
// level irq, and NUM_PWM PWM channels sharing one counter.
module mmio_timer_pwm
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00,
  parameter int          NUM_PWM   = 4,
  parameter int          PWM_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         funct3,
  input  logic               wren,
  input  logic [31:0]        address,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               hit,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);

  localparam int unsigned US_DIV = CLK_FREQ / 1000000;
  localparam int unsigned MS_DIV = CLK_FREQ / 1000;
  localparam int USW = $clog2(US_DIV + 1);
  localparam int MSW = $clog2(MS_DIV + 1);

  logic [USW-1:0] us_cnt;
  logic [MSW-1:0] ms_cnt;
  logic           us_tick, ms_tick;
  logic [31:0]    micros, millis, tcmp, tcount;
  logic           en, ar, pend;

  logic [NUM_PWM-1:0][PWM_WIDTH-1:0] duty;
  logic [PWM_WIDTH-1:0]              pcnt;
  logic                              pwrap;

  wr_lanes_t   wl;
  logic [5:0]  widx;
  logic        wr, cmp_wr, ctrl_wr, match;
  logic [7:0]  ctrl_wb;
  logic [31:0] rword;

  assign hit     = (address[31:8] == BASE_ADDR[31:8]);
  assign widx    = address[7:2];
  assign wr      = wren & hit;
  assign wl      = steer_write(funct3, address[1:0], data_in);
  assign cmp_wr  = wr && (widx == W_TCMP);
  assign ctrl_wr = wr && (widx == W_TCTRL) && wl.mask[0];
  assign ctrl_wb = wl.data[7:0];
  assign us_tick = (us_cnt == USW'(US_DIV - 1));
  assign ms_tick = (ms_cnt == MSW'(MS_DIV - 1));
  assign match   = us_tick && en && (tcount == tcmp);
  assign irq     = pend;
  assign pwrap   = &pcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      us_cnt <= '0;
      ms_cnt <= '0;
      micros <= '0;
      millis <= '0;
    end else begin
      us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
      ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
      if (us_tick) micros <= micros + 32'd1;
      if (ms_tick) millis <= millis + 32'd1;
    end
  end

  // Register writes are applied after the tick update so they override count/enable;
  // only pending gives priority to a same-cycle match over its W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcmp   <= '0;
      tcount <= '0;
      en     <= 1'b0;
      ar     <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (us_tick && en) begin
        if (tcount == tcmp) begin
          pend <= 1'b1;
          if (ar) tcount <= '0;
          else    en     <= 1'b0;
        end else begin
          tcount <= tcount + 32'd1;
        end
      end
      if (ctrl_wr) begin
        en <= ctrl_wb[CTRL_EN];
        ar <= ctrl_wb[CTRL_AR];
        if (ctrl_wb[CTRL_PEND] && !match) pend <= 1'b0;
        if (ctrl_wb[CTRL_EN] && !en) tcount <= '0;
      end
      if (cmp_wr) begin
        tcmp   <= merge_lanes(tcmp, wl);
        tcount <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty <= '0;
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
      for (int n = 0; n < NUM_PWM; n++)
        if (wr && widx == 6'(W_PWM0 + n))
          duty[n] <= PWM_WIDTH'(merge_lanes(32'(duty[n]), wl));
    end
  end

  for (genvar n = 0; n < NUM_PWM; n++) begin : g_pwm
    pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
      .clk  (clk),
      .reset(reset),
      .cnt  (pcnt),
      .wrap (pwrap),
      .duty (duty[n]),
      .pwm  (pwm_out[n])
    );
  end

  always_comb begin
    rword = '0;
    case (widx)
      W_MICROS: rword = micros;
      W_MILLIS: rword = millis;
      W_TCMP:   rword = tcmp;
      W_TCTRL: begin
        rword[CTRL_EN]   = en;
        rword[CTRL_AR]   = ar;
        rword[CTRL_PEND] = pend;
      end
      default: begin
        for (int n = 0; n < NUM_PWM; n++)
          if (widx == 6'(W_PWM0 + n)) rword = 32'(duty[n]);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else       data_out <= hit ? rword : '0;
  end

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Randomized register/PWM bench plus directed timer sequences for mmio_timer_pwm.
module tb_mmio_timer_pwm;

  localparam logic [31:0] BASE  = 32'hFFFFFF00;
  localparam logic [31:0] NOHIT = 32'h12345600;
  localparam int          NP    = 4;
  localparam logic [2:0]  F_B   = 3'b000;
  localparam logic [2:0]  F_W   = 3'b010;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    funct3 = 3'b0;
  logic          wren = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic          hit;
  logic [NP-1:0] pwm_out;
  logic          irq;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned hi [NP];
  logic [7:0]  mb [8][4];

  mmio_timer_pwm #(.CLK_FREQ(12000000), .BASE_ADDR(BASE), .NUM_PWM(NP), .PWM_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .funct3(funct3), .wren(wren), .address(address),
    .data_in(data_in), .data_out(data_out), .hit(hit), .pwm_out(pwm_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // cyc = rising edges since reset release; hi[n] = cycles pwm_out[n] was high
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
    for (int n = 0; n < NP; n++) if (pwm_out[n] === 1'b1) hi[n] <= hi[n] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] lo,
                     input logic [31:0] hi_b);
    checks++;
    if ($isunknown(got) || got < lo || got > hi_b) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h..%0h", tag, got, lo, hi_b);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [2:0] f3, input logic [31:0] d,
                    input logic [31:0] base = BASE);
    address = base | {24'h0, off};
    funct3 = f3; data_in = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] q, input logic [31:0] base = BASE);
    address = base | {24'h0, off};
    wren = 1'b0;
    @(negedge clk);
    q = data_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input logic lvl, input int bound, output int n);
    n = 0;
    while (irq !== lvl && n < bound) begin @(negedge clk); n++; end
  endtask

  // byte-lane model of the spec's access-size rules
  task automatic model_wr(input int w, input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
    if (f3[1]) begin
      for (int i = 0; i < 4; i++) mb[w][i] = d[8*i +: 8];
    end else if (f3[0]) begin
      mb[w][{lo[1], 1'b0}] = d[7:0];
      mb[w][{lo[1], 1'b1}] = d[15:8];
    end else begin
      mb[w][lo] = d[7:0];
    end
  endtask

  function automatic logic [31:0] model_rd(input int w);
    if (w == 2) return {mb[2][3], mb[2][2], mb[2][1], mb[2][0]};
    return {24'h0, mb[w][0]};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, e;
    int n, c0, c1, c2, nd;
    int unsigned h0;
    int unsigned hs [NP];
    for (int w = 0; w < 8; w++) for (int i = 0; i < 4; i++) mb[w][i] = 8'h0;

    #2 reset = 1'b1;
    idle(3);
    chk("rst_data_out", data_out, 0, 0);
    chk("rst_pwm", 32'(pwm_out), 0, 0);
    chk("rst_irq", 32'(irq), 0, 0);
    address = BASE | 32'h44; #1;
    chk("hit_base", 32'(hit), 1, 1);
    address = 32'h00000100; #1;
    chk("hit_other", 32'(hit), 0, 0);
    @(negedge clk) reset = 1'b0;

    // timebase
    while (cyc < 119) @(negedge clk);
    rd(8'h00, q);
    chk("micros_120", q, 9, 11);
    while (cyc < 12100) @(negedge clk);
    rd(8'h04, q);
    chk("millis_12100", q, 1, 1);
    e = cyc / 12;
    rd(8'h00, q);
    chk("micros_12100", q, e - 1, e + 1);
    rd(8'h08, q, NOHIT);
    chk("nohit_read", q, 0, 0);

    // random register traffic against the byte-lane model
    for (int it = 0; it < 40; it++) begin
      int w, k;
      logic [2:0] f3;
      logic [1:0] lo;
      logic [31:0] d;
      k = $urandom_range(0, 4);
      w = (k == 0) ? 2 : k + 3;
      f3 = 3'($urandom_range(0, 7));
      lo = 2'($urandom_range(0, 3));
      d = $urandom;
      wr(8'(w * 4 + int'(lo)), f3, d);
      model_wr(w, f3, lo, d);
      rd(8'(w * 4), q);
      chk("rand_rw", q, model_rd(w), model_rd(w));
      k = $urandom_range(0, 3);
      d = $urandom;
      case (k)
        0: wr(8'h04, F_W, d);
        1: wr(8'h00, F_W, d);
        2: wr(8'($urandom_range(8, 63) * 4), F_W, d);
        default: wr(8'h08, F_W, d, NOHIT);
      endcase
      rd(8'h08, q);
      chk("ignored_wr_cmp", q, model_rd(2), model_rd(2));
      rd(8'($urandom_range(8, 63) * 4), q);
      chk("unmapped_rd", q, 0, 0);
      e = cyc;
      rd(8'h04, q);
      chk("ignored_wr_millis", q, (e - 2) / 12000, (e + 2) / 12000);
    end

    // every channel's high time over a full period equals its model duty
    idle(520);
    for (int c = 0; c < NP; c++) hs[c] = hi[c];
    idle(256);
    for (int c = 0; c < NP; c++)
      chk("pwm_duty_rand", hi[c] - hs[c], 32'(mb[4 + c][0]), 32'(mb[4 + c][0]));

    // upper duty lanes are not stored
    wr(8'h10, F_W, 32'h0);
    wr(8'h11, F_B, 32'h80);
    rd(8'h10, q);
    chk("duty_upper_masked", q, 0, 0);
    wr(8'h10, F_B, 32'h80);
    rd(8'h10, q);
    chk("duty_byte_rd", q, 32'h80, 32'h80);
    idle(520);
    n = 0;
    while (pwm_out[0] !== 1'b0 && n < 600) begin @(negedge clk); n++; end
    while (pwm_out[0] !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk("pwm_rise_found", 32'(n), 0, 599);
    c0 = cyc; h0 = hi[0];
    idle(20);
    nd = $urandom_range(1, 255);
    wr(8'h10, F_W, 32'(nd));
    while (cyc < c0 + 256) @(negedge clk);
    chk("pwm_glitchfree", hi[0] - h0, 128, 128);
    chk("pwm_new_period", 32'(pwm_out[0]), 1, 1);
    h0 = hi[0];
    idle(256);
    chk("pwm_new_duty", hi[0] - h0, nd, nd);

    // auto-reload timer
    wr(8'h08, F_W, 5);
    wr(8'h0C, F_W, 3);
    wait_irq(1'b1, 200, n);
    chk("ar_first_latency", 32'(n), 60, 84);
    c1 = cyc;
    wr(8'h0C, F_W, 7);
    chk("ar_w1c", 32'(irq), 0, 0);
    rd(8'h0C, q);
    chk("ar_ctrl_rd", q, 3, 3);
    wait_irq(1'b1, 200, n);
    chk("ar_period", cyc - c1, 72, 72);
    c2 = cyc;
    wr(8'h0C, F_W, 7);
    chk("ar_w1c2", 32'(irq), 0, 0);
    while (cyc < c2 + 71) @(negedge clk);
    wr(8'h0C, F_W, 7);
    chk("w1c_vs_match", 32'(irq), 1, 1);
    wr(8'h0C, F_W, 4);
    chk("disable_clear", 32'(irq), 0, 0);
    rd(8'h0C, q);
    chk("ctrl_off", q, 0, 0);

    // one-shot timer
    wr(8'h08, F_W, 2);
    wr(8'h0C, F_W, 1);
    wait_irq(1'b1, 100, n);
    chk("os_latency", 32'(n), 25, 36);
    rd(8'h0C, q);
    chk("os_ctrl_rd", q, 4, 4);
    wr(8'h0C, F_W, 4);
    chk("os_w1c", 32'(irq), 0, 0);
    idle(100);
    chk("os_no_rematch", 32'(irq), 0, 0);

    // reset mid-operation
    wr(8'h10, F_B, 32'hFF);
    wr(8'h14, F_W, 32'h80);
    wr(8'h08, F_W, 0);
    wr(8'h0C, F_W, 1);
    wait_irq(1'b1, 40, n);
    chk("cmp0_first_tick", 32'(n), 1, 12);
    idle(300);
    n = 0;
    while (pwm_out[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("pre_rst_pwm", 32'(pwm_out[0]), 1, 1);
    reset = 1'b1; #1;
    chk("rst_async_pwm", 32'(pwm_out), 0, 0);
    chk("rst_async_irq", 32'(irq), 0, 0);
    chk("rst_async_dout", data_out, 0, 0);
    @(negedge clk) reset = 1'b0;
    for (int w = 0; w < 8; w++) begin
      rd(8'(w * 4), q);
      chk("rst_reads", q, 0, 0);
    end
    while (cyc < 20) @(negedge clk);
    rd(8'h00, q);
    chk("prescaler_restart", q, 1, 1);
    idle(300);
    chk("rst_pwm_idle", 32'(pwm_out), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
